// File: rtl/wb_arbiter_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_n_pkg
//  Description : Shared definitions for the N-master Wishbone arbiter.
//                Holds the FSM state encodings, the timeout counter width
//                and the flattened-bus slice helper macro.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef WB_ARBITER_N_PKG_SV
`define WB_ARBITER_N_PKG_SV

// Select slice idx (width w) out of a flattened per-master vector
`define WB_ARB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package wb_arbiter_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ABORT   = 2'd2
    } arb_state_t;

    localparam int TMO_CNT_WIDTH = 16;

endpackage

`endif
`default_nettype wire

// File: rtl/wb_arb_select.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_select
//  Description : Combinational winner selection. Produces a one-hot grant
//                from the request vector using either round robin (search
//                upward from ptr+1, wrapping) or fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_select
    import wb_arbiter_n_pkg::*;
#(
    parameter int NUM_MASTERS       = 4,
    parameter int ROUND_ROBIN       = 1,
    parameter int LSB_HIGH_PRIORITY = 1,
    parameter int PTR_WIDTH         = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_WIDTH-1:0]   ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   valid
);

    assign valid = |req;

    generate
        if (ROUND_ROBIN != 0) begin : g_round_robin
            // Farthest candidates first so the nearest requester after ptr overwrites last
            always_comb begin
                grant = '0;
                for (int off = NUM_MASTERS; off >= 1; off--) begin
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (req[i] && (i == ((int'(ptr) + off) % NUM_MASTERS))) begin
                            grant    = '0;
                            grant[i] = 1'b1;
                        end
                    end
                end
            end
        end else if (LSB_HIGH_PRIORITY != 0) begin : g_fixed_lsb
            // Descending scan: the lowest requesting index is assigned last and wins
            always_comb begin
                grant = '0;
                for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        grant    = '0;
                        grant[i] = 1'b1;
                    end
                end
            end
        end else begin : g_fixed_msb
            // Ascending scan: the highest requesting index is assigned last and wins
            always_comb begin
                grant = '0;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (req[i]) begin
                        grant    = '0;
                        grant[i] = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_n
//  Description : N-master to 1-slave classic Wishbone arbiter with registered
//                grant, round-robin or fixed-priority selection, error
//                pass-through and optional slave-response timeout.
//                Optional feature macro: WB_ARB_TIMEOUT_EN (timeout/abort).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_n
    import wb_arbiter_n_pkg::*;
#(
    parameter int NUM_MASTERS           = 4,
    parameter int DATA_WIDTH            = 32,
    parameter int ADDR_WIDTH            = 32,
    parameter int SELECT_WIDTH          = DATA_WIDTH / 8,
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 1,
    parameter int TIMEOUT_CYCLES        = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [NUM_MASTERS-1:0]              wbm_we_i,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]              wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]              wbm_cyc_i,
    output logic [NUM_MASTERS-1:0]              wbm_ack_o,
    output logic [NUM_MASTERS-1:0]              wbm_err_o,
    output logic [ADDR_WIDTH-1:0]               wbs_adr_o,
    output logic [DATA_WIDTH-1:0]               wbs_dat_o,
    output logic                                wbs_we_o,
    output logic [SELECT_WIDTH-1:0]             wbs_sel_o,
    output logic                                wbs_stb_o,
    output logic                                wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]               wbs_dat_i,
    input  logic                                wbs_ack_i,
    input  logic                                wbs_err_i,
    output logic [NUM_MASTERS-1:0]              grant_o,
    output logic                                grant_valid_o
);

    localparam int PTR_WIDTH = $clog2(NUM_MASTERS);

    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > 16 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
            $error("wb_arbiter_n: parameter out of range");
        end
    endgenerate

    arb_state_t             state, state_next;
    logic [NUM_MASTERS-1:0] grant_next, sel_grant;
    logic                   sel_valid;
    logic [PTR_WIDTH-1:0]   ptr, ptr_next, gidx;
    logic                   gnt_cyc, gnt_stb, tmo_hit;

    wb_arb_select #(
        .NUM_MASTERS       (NUM_MASTERS),
        .ROUND_ROBIN       (ARB_TYPE_ROUND_ROBIN),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY),
        .PTR_WIDTH         (PTR_WIDTH)
    ) u_select (
        .req   (wbm_cyc_i),
        .ptr   (ptr),
        .grant (sel_grant),
        .valid (sel_valid)
    );

    // Encode the registered one-hot grant into an index for muxing
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_o[i]) gidx = PTR_WIDTH'(i);
        end
    end

    assign gnt_cyc       = wbm_cyc_i[gidx];
    assign gnt_stb       = wbm_stb_i[gidx];
    assign grant_valid_o = (state == ST_GRANTED);
    assign wbm_dat_o     = {NUM_MASTERS{wbs_dat_i}};

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [TMO_CNT_WIDTH-1:0] TMO_LIMIT = TMO_CNT_WIDTH'(TIMEOUT_CYCLES);
    logic [TMO_CNT_WIDTH-1:0] tmo_cnt;
    logic                     stalled;

    // Ack or err in the terminal cycle suppresses the abort
    assign stalled = (state == ST_GRANTED) && gnt_cyc && gnt_stb && !wbs_ack_i && !wbs_err_i;
    assign tmo_hit = stalled && (tmo_cnt == TMO_LIMIT);

    // Count consecutive stalled strobe cycles; any response or exit clears it
    always_ff @(posedge clk) begin
        if (rst)                     tmo_cnt <= '0;
        else if (stalled && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
        else                         tmo_cnt <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            ptr     <= PTR_WIDTH'(NUM_MASTERS - 1);
        end else begin
            state   <= state_next;
            grant_o <= grant_next;
            ptr     <= ptr_next;
        end
    end

    // Next-state logic and slave/master muxing
    always_comb begin
        state_next = state;
        grant_next = grant_o;
        ptr_next   = ptr;
        wbs_adr_o  = '0;
        wbs_dat_o  = '0;
        wbs_we_o   = 1'b0;
        wbs_sel_o  = '0;
        wbs_stb_o  = 1'b0;
        wbs_cyc_o  = 1'b0;
        wbm_ack_o  = '0;
        wbm_err_o  = '0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_next = sel_grant;
                    state_next = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (!gnt_cyc) begin
                    // Release regardless of stb; the bus goes quiet this cycle
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = gidx;
                end else begin
                    wbs_adr_o       = `WB_ARB_SLICE(wbm_adr_i, gidx, ADDR_WIDTH);
                    wbs_dat_o       = `WB_ARB_SLICE(wbm_dat_i, gidx, DATA_WIDTH);
                    wbs_sel_o       = `WB_ARB_SLICE(wbm_sel_i, gidx, SELECT_WIDTH);
                    wbs_we_o        = wbm_we_i[gidx];
                    wbs_stb_o       = gnt_stb;
                    wbs_cyc_o       = 1'b1;
                    wbm_ack_o[gidx] = wbs_ack_i;
                    wbm_err_o[gidx] = wbs_err_i;
                    if (tmo_hit) begin
                        wbs_stb_o       = 1'b0;
                        wbs_cyc_o       = 1'b0;
                        wbm_err_o[gidx] = 1'b1;
                        state_next      = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                // Slave side stays quiet until the aborted master lets go
                if (!gnt_cyc) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = gidx;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter_n
//  Description : Directed self-checking bench. Instance 0 is round robin,
//                instance 1 fixed priority LSB-high, instance 2 fixed
//                priority MSB-high; all share the master/slave stimulus.
//                Timeout scenario built only with WB_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_n;

    localparam int NM   = 4;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int SW   = 4;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*SW-1:0] m_sel;
    logic [NM-1:0]    m_we, m_stb, m_cyc;
    logic [DW-1:0]    s_dat;
    logic             s_ack, s_err;

    logic [NM*DW-1:0] o_mdat [NDUT];
    logic [NM-1:0]    o_ack  [NDUT];
    logic [NM-1:0]    o_err  [NDUT];
    logic [NM-1:0]    o_gnt  [NDUT];
    logic             o_gv   [NDUT];
    logic [AW-1:0]    o_sadr [NDUT];
    logic [DW-1:0]    o_sdat [NDUT];
    logic [SW-1:0]    o_ssel [NDUT];
    logic             o_swe  [NDUT];
    logic             o_sstb [NDUT];
    logic             o_scyc [NDUT];

    int checks = 0;
    int errors = 0;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            wb_arbiter_n #(
                .NUM_MASTERS           (NM),
                .DATA_WIDTH            (DW),
                .ADDR_WIDTH            (AW),
                .SELECT_WIDTH          (SW),
                .ARB_TYPE_ROUND_ROBIN  ((g == 0) ? 1 : 0),
                .ARB_LSB_HIGH_PRIORITY ((g == 2) ? 0 : 1),
                .TIMEOUT_CYCLES        (8)
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .wbm_adr_i     (m_adr),
                .wbm_dat_i     (m_dat),
                .wbm_dat_o     (o_mdat[g]),
                .wbm_we_i      (m_we),
                .wbm_sel_i     (m_sel),
                .wbm_stb_i     (m_stb),
                .wbm_cyc_i     (m_cyc),
                .wbm_ack_o     (o_ack[g]),
                .wbm_err_o     (o_err[g]),
                .wbs_adr_o     (o_sadr[g]),
                .wbs_dat_o     (o_sdat[g]),
                .wbs_we_o      (o_swe[g]),
                .wbs_sel_o     (o_ssel[g]),
                .wbs_stb_o     (o_sstb[g]),
                .wbs_cyc_o     (o_scyc[g]),
                .wbs_dat_i     (s_dat),
                .wbs_ack_i     (s_ack),
                .wbs_err_i     (s_err),
                .grant_o       (o_gnt[g]),
                .grant_valid_o (o_gv[g])
            );
        end
    endgenerate

    function automatic logic [AW-1:0] adr_of(input int k);
        return 32'hA000_0000 + 32'(k) * 32'h100;
    endfunction

    // Advance one clock; inputs are driven 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = 4'b1010;
        s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
        for (int k = 0; k < NM; k++) begin
            m_adr[k*AW +: AW] = adr_of(k);
            m_dat[k*DW +: DW] = 32'hD000_0000 + 32'(k);
            m_sel[k*SW +: SW] = 4'(k + 1);
        end
        tick(); tick();
        #1;
        for (int g = 0; g < NDUT; g++) begin
            checks++;
            if (o_gnt[g] !== 4'b0000 || o_gv[g] !== 1'b0) begin
                errors++; $display("FAIL reset_grant dut=%0d got %b/%b exp 0000/0", g, o_gnt[g], o_gv[g]);
            end
            checks++;
            if ({o_scyc[g], o_sstb[g], o_swe[g], o_sadr[g], o_ssel[g]} !== '0) begin
                errors++; $display("FAIL reset_slave dut=%0d got cyc=%b stb=%b adr=%h exp all 0", g, o_scyc[g], o_sstb[g], o_sadr[g]);
            end
            checks++;
            if (o_ack[g] !== 4'b0000 || o_err[g] !== 4'b0000) begin
                errors++; $display("FAIL reset_resp dut=%0d got ack=%b err=%b exp 0", g, o_ack[g], o_err[g]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] exp_oh;
        int            e;
        m_cyc = 4'b1111; m_stb = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e      = k % NM;
            exp_oh = 4'b0001 << e;
            tick(); #1;
            checks++;
            if (o_gnt[0] !== exp_oh || o_gv[0] !== 1'b1) begin
                errors++; $display("FAIL rr_grant k=%0d got %b/%b exp %b/1", k, o_gnt[0], o_gv[0], exp_oh);
            end
            checks++;
            if (o_scyc[0] !== 1'b1 || o_sadr[0] !== adr_of(e) || o_swe[0] !== e[0]) begin
                errors++; $display("FAIL rr_mux k=%0d got cyc=%b adr=%h we=%b exp 1/%h/%b", k, o_scyc[0], o_sadr[0], o_swe[0], adr_of(e), e[0]);
            end
            s_ack = 1'b1; #1;
            checks++;
            if (o_ack[0] !== exp_oh) begin
                errors++; $display("FAIL rr_ack k=%0d got %b exp %b", k, o_ack[0], exp_oh);
            end
            tick();
            s_ack = 1'b0; m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
            tick(); #1;
            checks++;
            if (o_scyc[0] !== 1'b0 || o_gnt[0] !== 4'b0000) begin
                errors++; $display("FAIL rr_gap k=%0d got cyc=%b gnt=%b exp 0/0000", k, o_scyc[0], o_gnt[0]);
            end
            m_cyc[e] = 1'b1; m_stb[e] = 1'b1;
        end
        m_cyc = '0; m_stb = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_fixed_priority();
        m_cyc = 4'b1010; m_stb = 4'b1010;
        tick(); #1;
        checks++;
        if (o_gnt[1] !== 4'b0010) begin
            errors++; $display("FAIL fixed_lsb got %b exp 0010", o_gnt[1]);
        end
        checks++;
        if (o_gnt[2] !== 4'b1000) begin
            errors++; $display("FAIL fixed_msb got %b exp 1000", o_gnt[2]);
        end
        checks++;
        if (o_gnt[0] !== 4'b0010) begin
            errors++; $display("FAIL rr_after_ptr0 got %b exp 0010", o_gnt[0]);
        end
        m_cyc = '0; m_stb = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_ack = 1'b1; #1;
            checks++;
            if (o_gnt[0] !== 4'b0100 || o_ack[0] !== 4'b0100 || o_swe[0] !== 1'b1) begin
                errors++; $display("FAIL hold_xfer i=%0d got gnt=%b ack=%b we=%b exp 0100/0100/1", i, o_gnt[0], o_ack[0], o_swe[0]);
            end
            tick();
        end
        s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
        tick(); #1;
        checks++;
        if (o_scyc[0] !== 1'b0 || o_gnt[0] !== 4'b0000) begin
            errors++; $display("FAIL hold_gap got cyc=%b gnt=%b exp 0/0000", o_scyc[0], o_gnt[0]);
        end
        tick(); #1;
        checks++;
        if (o_gnt[0] !== 4'b0001 || o_sadr[0] !== adr_of(0)) begin
            errors++; $display("FAIL hold_next got gnt=%b adr=%h exp 0001/%h", o_gnt[0], o_sadr[0], adr_of(0));
        end
        m_cyc = '0; m_stb = '0;
        tick(); tick();
    endtask

    task automatic test_error();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick(); #1;
        checks++;
        if (o_gnt[0] !== 4'b0010) begin
            errors++; $display("FAIL err_grant got %b exp 0010", o_gnt[0]);
        end
        s_err = 1'b1; s_dat = 32'hCAFE_F00D; #1;
        checks++;
        if (o_err[0] !== 4'b0010 || o_ack[0] !== 4'b0000) begin
            errors++; $display("FAIL err_route got err=%b ack=%b exp 0010/0000", o_err[0], o_ack[0]);
        end
        checks++;
        if (o_mdat[0][1*DW +: DW] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rdata got %h exp cafef00d", o_mdat[0][1*DW +: DW]);
        end
        tick();
        s_err = 1'b0; #1;
        checks++;
        if (o_gnt[0] !== 4'b0010 || o_gv[0] !== 1'b1 || o_err[0] !== 4'b0000) begin
            errors++; $display("FAIL err_hold got gnt=%b gv=%b err=%b exp 0010/1/0000", o_gnt[0], o_gv[0], o_err[0]);
        end
        m_cyc = '0; m_stb = '0;
        tick(); tick();
    endtask

    task automatic test_idle_response();
        s_ack = 1'b1; s_err = 1'b1; #1;
        checks++;
        if (o_ack[0] !== 4'b0000 || o_err[0] !== 4'b0000) begin
            errors++; $display("FAIL idle_resp got ack=%b err=%b exp 0000/0000", o_ack[0], o_err[0]);
        end
        s_ack = 1'b0; s_err = 1'b0;
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        tick();
        for (int j = 0; j < 8; j++) begin
            #1;
            checks++;
            if (o_err[0] !== 4'b0000 || o_scyc[0] !== 1'b1) begin
                errors++; $display("FAIL tmo_stall j=%0d got err=%b cyc=%b exp 0000/1", j, o_err[0], o_scyc[0]);
            end
            tick();
        end
        #1;
        checks++;
        if (o_err[0] !== 4'b1000 || o_scyc[0] !== 1'b0) begin
            errors++; $display("FAIL tmo_fire got err=%b cyc=%b exp 1000/0", o_err[0], o_scyc[0]);
        end
        tick();
        s_ack = 1'b1; #1;
        checks++;
        if (o_ack[0] !== 4'b0000 || o_err[0] !== 4'b0000 || o_scyc[0] !== 1'b0) begin
            errors++; $display("FAIL tmo_abort got ack=%b err=%b cyc=%b exp 0000/0000/0", o_ack[0], o_err[0], o_scyc[0]);
        end
        checks++;
        if (o_gnt[0] !== 4'b1000 || o_gv[0] !== 1'b0) begin
            errors++; $display("FAIL tmo_abort_gnt got %b/%b exp 1000/0", o_gnt[0], o_gv[0]);
        end
        s_ack = 1'b0; m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
        tick(); #1;
        checks++;
        if (o_gnt[0] !== 4'b0000) begin
            errors++; $display("FAIL tmo_idle got %b exp 0000", o_gnt[0]);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick(); #1;
        checks++;
        if (o_scyc[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got cyc=%b exp 1", o_scyc[0]);
        end
        rst = 1'b1;
        tick(); #1;
        checks++;
        if (o_gnt[0] !== 4'b0000 || o_gv[0] !== 1'b0 || o_scyc[0] !== 1'b0 ||
            o_sstb[0] !== 1'b0 || o_sadr[0] !== '0 || o_swe[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear got gnt=%b gv=%b cyc=%b stb=%b adr=%h exp all 0", o_gnt[0], o_gv[0], o_scyc[0], o_sstb[0], o_sadr[0]);
        end
        rst = 1'b0; m_cyc = 4'b0101; m_stb = 4'b0101;
        tick(); #1;
        checks++;
        if (o_gnt[0] !== 4'b0001) begin
            errors++; $display("FAIL rstmid_first got %b exp 0001", o_gnt[0]);
        end
        m_cyc = '0; m_stb = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_back_to_back();
        test_error();
        test_idle_response();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
